// File: rtl/dmem_arbiter.sv
// Round-robin share of one single-port dmem between LSU (port 0) and debug/DMA (port 1).
// Accept->response latency 2 cycles; at most one request in flight, req_ready is low during ACCESS.
module dmem_arbiter #(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_we,
   input  logic [3:0]  req_size,
   input  logic [1:0]  req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } hold_t;

   state_t      r_state;
   hold_t       r_hold;
   logic        r_last_grant;
   logic [1:0]  r_resp_valid;
   logic        r_resp_err;

   hold_t       w_req;
   logic        w_win;
   logic        w_accept;
   logic        w_mis;
   logic        w_err;
   logic [3:0]  w_be;
   logic [31:0] w_wd;
   logic [31:0] w_lane;
   logic [31:0] w_ext;

   // A tie goes to the port that did not win last; a lone requester always wins.
   always_comb begin
      w_win    = (&req_valid) ? ~r_last_grant : req_valid[1];
      w_accept = (r_state != ACCESS) && (|req_valid);
      req_ready = 2'b00;
      if (w_accept) req_ready = w_win ? 2'b10 : 2'b01;
      w_req.port  = w_win;
      w_req.we    = w_win ? req_we[1]        : req_we[0];
      w_req.size  = w_win ? req_size[3:2]    : req_size[1:0];
      w_req.uns   = w_win ? req_unsigned[1]  : req_unsigned[0];
      w_req.addr  = w_win ? req_addr[63:32]  : req_addr[31:0];
      w_req.wdata = w_win ? req_wdata[63:32] : req_wdata[31:0];
   end

   always_comb begin
      w_mis = 1'b0;
      w_be  = 4'b0000;
      w_wd  = r_hold.wdata;
      case (r_hold.size)
         2'b00: begin
            w_be = 4'b0001 << r_hold.addr[1:0];
            w_wd = {4{r_hold.wdata[7:0]}};
         end
         2'b01: begin
            w_mis = r_hold.addr[0];
            w_be  = r_hold.addr[1] ? 4'b1100 : 4'b0011;
            w_wd  = {2{r_hold.wdata[15:0]}};
         end
         2'b10: begin
            w_mis = |r_hold.addr[1:0];
            w_be  = 4'b1111;
         end
         default: w_mis = 1'b1;
      endcase
      w_err = w_mis || ({2'b00, r_hold.addr[31:2]} >= DEPTH_WORDS);

      mem_we   = 1'b0;
      mem_be   = 4'b0000;
      mem_addr = 32'h0;
      mem_wd   = 32'h0;
      if ((r_state == ACCESS) && !w_err) begin
         mem_we   = r_hold.we;
         mem_be   = w_be;
         mem_addr = {r_hold.addr[31:2], 2'b00};
         mem_wd   = w_wd;
      end
   end

   // r_hold still describes the responding request in RESP; it is only overwritten at the end of that cycle.
   always_comb begin
      w_lane = mem_rd >> {r_hold.addr[1:0], 3'b000};
      case (r_hold.size)
         2'b00:   w_ext = r_hold.uns ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
         2'b01:   w_ext = r_hold.uns ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
         default: w_ext = w_lane;
      endcase
      resp_rdata = ((|r_resp_valid) && !r_resp_err && !r_hold.we) ? w_ext : 32'h0;
      resp_valid = r_resp_valid;
      resp_err   = r_resp_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_hold       <= '0;
         r_last_grant <= 1'b1;
         r_resp_valid <= 2'b00;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 2'b00;
         r_resp_err   <= 1'b0;
         case (r_state)
            ACCESS: begin
               r_resp_valid <= r_hold.port ? 2'b10 : 2'b01;
               r_resp_err   <= w_err;
               r_state      <= RESP;
            end
            default: begin
               if (w_accept) begin
                  r_hold       <= w_req;
                  r_last_grant <= w_win;
                  r_state      <= ACCESS;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle corner sequences, randomized traffic vs a byte-level model.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_we, req_unsigned, resp_valid;
   logic [3:0]  req_size, mem_be;
   logic [63:0] req_addr, req_wdata;
   logic        resp_err, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } rq_t;
   typedef struct {
      rq_t         r;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } vec_t;
   typedef struct {
      int          due;
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic [31:0] phys [0:255] = '{default: 32'h0};
   logic [7:0]  ref_mem [0:1023] = '{default: 8'h0};

   dmem_arbiter #(.DEPTH_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Single-port memory with registered read.
   always @(posedge clk) begin
      if (mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) phys[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      mem_rd <= phys[mem_addr[9:2]];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input rq_t r);
      int p;
      p = int'(r.port);
      req_we[p]              = r.we;
      req_size[2*p +: 2]     = r.size;
      req_unsigned[p]        = r.uns;
      req_addr[32*p +: 32]   = r.addr;
      req_wdata[32*p +: 32]  = r.wdata;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic p, input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wdat, input logic e,
                               input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
      vec_t v;
      v.r.port = p; v.r.we = we; v.r.size = sz; v.r.uns = u; v.r.addr = a; v.r.wdata = wdat;
      v.err = e; v.be = be; v.wd = wd; v.rdata = rd;
      return v;
   endfunction

   // One isolated request: accept, ACCESS-cycle memory drive, RESP-cycle response, then idle.
   task automatic run_vec(input vec_t v, input int idx);
      int n;
      @(negedge clk);
      drive(v.r);
      req_valid[v.r.port] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[v.r.port] && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("vec%0d_ready", idx), 32'(req_ready[v.r.port]), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_we", idx), 32'(mem_we), 32'(v.r.we & ~v.err));
      chk($sformatf("vec%0d_mem_be", idx), 32'(mem_be), 32'(v.err ? 4'h0 : v.be));
      if (!v.err) chk($sformatf("vec%0d_mem_addr", idx), mem_addr, {v.r.addr[31:2], 2'b00});
      if (!v.err && v.r.we) chk($sformatf("vec%0d_mem_wd", idx), mem_wd, v.wd);
      @(negedge clk);
      chk($sformatf("vec%0d_resp_valid", idx), 32'(resp_valid), v.r.port ? 32'h2 : 32'h1);
      chk($sformatf("vec%0d_resp_err", idx), 32'(resp_err), 32'(v.err));
      chk($sformatf("vec%0d_resp_rdata", idx), resp_rdata, v.rdata);
      chk($sformatf("vec%0d_resp_mem_we", idx), 32'({mem_we, mem_be}), 32'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_resp_done", idx), 32'(resp_valid), 32'h0);
   endtask

   // Byte-granular reference: error rule, then store bytes or assemble and extend a load.
   task automatic model(input rq_t r, input int due, output rsp_t o);
      int nb;
      logic [31:0] v;
      o.due = due; o.port = r.port; o.rdata = 32'h0;
      o.err = (r.size == 2'b11) || (r.size == 2'b01 && r.addr[0]) ||
              (r.size == 2'b10 && r.addr[1:0] != 2'b00) || (r.addr / 4 >= 32'd256);
      if (!o.err) begin
         nb = 1 << r.size;
         if (r.we) begin
            for (int k = 0; k < nb; k++) ref_mem[int'(r.addr) + k] = r.wdata[8*k +: 8];
         end else begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v = v + (32'(ref_mem[int'(r.addr) + k]) << (8*k));
            if (!r.uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
            o.rdata = v;
         end
      end
   endtask

   function automatic rq_t rand_req(input logic p);
      rq_t r;
      r.port  = p;
      r.we    = 1'($urandom_range(0, 1));
      r.uns   = 1'($urandom_range(0, 1));
      r.size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r.addr  = (($urandom_range(0, 11) == 0) ? 32'h400 : 32'h100) + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
         if (r.size == 2'b01) r.addr[0] = 1'b0;
         else if (r.size == 2'b10) r.addr[1:0] = 2'b00;
      end
      r.wdata = $urandom;
      return r;
   endfunction

   vec_t        vt[$];
   rsp_t        q[$];
   rq_t         cur[2];
   rsp_t        rs;
   logic        lg;
   logic        win;
   logic [1:0]  erdy;
   int          last_acc;
   logic [31:0] wexp;

   initial begin
      req_valid = 2'b00; req_we = 2'b00; req_size = 4'h0; req_unsigned = 2'b00;
      req_addr = 64'h0; req_wdata = 64'h0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'h0);
      chk("reset_resp", 32'({resp_valid, resp_err}), 32'h0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk("reset_mem", 32'({mem_we, mem_be}), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wd", mem_wd, 32'h0);
      apply_reset();

      //               port  we    size   uns   addr          wdata          err   be     wd             rdata
      vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0));
      vt.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        1'b0, 4'h8, 32'h0,        32'hFFFFFFDE));
      vt.push_back(mk(1'b0, 1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        1'b0, 4'hC, 32'h0,        32'h0000DEAD));
      vt.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 4'hF, 32'h0,        32'hDEADBEEF));
      vt.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 1'b0, 4'hF, 32'h11223344, 32'h0));
      vt.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 32'h21,  32'hFFFFFF55, 1'b0, 4'h2, 32'h55555555, 32'h0));
      vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        1'b0, 4'hF, 32'h0,        32'h11225544));
      vt.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h6,   32'h0,        1'b1, 4'h0, 32'h0,        32'h0));
      vt.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h5,   32'h0000AAAA, 1'b1, 4'h0, 32'h0,        32'h0));
      vt.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        1'b0, 4'hF, 32'h0,        32'h0));
      vt.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        1'b1, 4'h0, 32'h0,        32'h0));
      vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 1'b1, 4'h0, 32'h0,        32'h0));
      vt.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 32'h12,  32'h1234ABCD, 1'b0, 4'hC, 32'hABCDABCD, 32'h0));
      vt.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 4'hF, 32'h0,        32'hABCDBEEF));
      vt.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        1'b0, 4'hC, 32'h0,        32'hFFFFABCD));
      vt.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1'b0, 4'h8, 32'h0,        32'h000000AB));
      vt.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0));
      vt.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        1'b0, 4'hF, 32'h0,        32'hCAFEF00D));
      vt.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h10,  32'h0,        1'b0, 4'h1, 32'h0,        32'hFFFFFFEF));
      vt.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        1'b0, 4'h3, 32'h0,        32'h0000BEEF));
      for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

      // Both ports requesting continuously from reset: alternate grants, one accept per 2 cycles.
      apply_reset();
      drive(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0).r);
      drive(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0).r);
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      for (int k = 0; k <= 8; k++) begin
         if (k % 2 == 1) wexp = 32'h0;
         else wexp = (k % 4 == 0) ? 32'h1 : 32'h2;
         chk($sformatf("rr%0d_ready", k), 32'(req_ready), wexp);
         if (k > 0 && k % 2 == 0) begin
            chk($sformatf("rr%0d_resp", k), 32'(resp_valid), ((k / 2) % 2 == 1) ? 32'h1 : 32'h2);
            chk($sformatf("rr%0d_rdata", k), resp_rdata, ((k / 2) % 2 == 1) ? 32'hABCDBEEF : 32'h11225544);
         end else begin
            chk($sformatf("rr%0d_resp", k), 32'(resp_valid), 32'h0);
         end
         if (k == 8) req_valid = 2'b00;
         else @(negedge clk);
      end

      // Reset pulled during the ACCESS cycle of a store: no write, no response.
      @(negedge clk);
      drive(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h77777777, 1'b0, 4'h0, 32'h0, 32'h0).r);
      req_valid = 2'b01;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("rst_access_we", 32'(mem_we), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_drop", 32'({mem_we, mem_be}), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_no_resp2", 32'(resp_valid), 32'h0);
      chk("rst_no_write", phys[12], 32'h0);
      run_vec(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0), 99);

      // Random two-port traffic checked against arbitration rules and the byte model.
      apply_reset();
      lg = 1'b1;
      last_acc = -10;
      for (int t = 0; t < 420; t++) begin
         @(negedge clk);
         erdy = 2'b00;
         win  = 1'b0;
         if (t != last_acc + 1 && req_valid != 2'b00) begin
            win  = (req_valid == 2'b11) ? ~lg : req_valid[1];
            erdy = win ? 2'b10 : 2'b01;
         end
         chk($sformatf("rnd%0d_ready", t), 32'(req_ready), 32'(erdy));
         if (q.size() > 0 && q[0].due == t) begin
            chk($sformatf("rnd%0d_resp_valid", t), 32'(resp_valid), q[0].port ? 32'h2 : 32'h1);
            chk($sformatf("rnd%0d_resp_err", t), 32'(resp_err), 32'(q[0].err));
            chk($sformatf("rnd%0d_resp_rdata", t), resp_rdata, q[0].rdata);
            void'(q.pop_front());
         end else begin
            chk($sformatf("rnd%0d_resp_idle", t), 32'(resp_valid), 32'h0);
         end
         if (erdy != 2'b00) begin
            model(cur[win], t + 2, rs);
            q.push_back(rs);
            lg = win;
            last_acc = t;
         end
         @(posedge clk);
         #1;
         if (erdy != 2'b00) req_valid[win] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (!req_valid[p] && t < 400 && $urandom_range(0, 1) == 1) begin
               cur[p] = rand_req(1'(p));
               drive(cur[p]);
               req_valid[p] = 1'b1;
            end
         end
      end
      req_valid = 2'b00;
      chk("rnd_drain", 32'(q.size()), 32'h0);
      for (int w = 64; w < 80; w++)
         chk($sformatf("rnd_mem_word%0d", w), phys[w],
             {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
